serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
//   Uses a single full-subtractor cell, the inverse operation of our ripple adder cells.
//   Accepts operands on a valid/ready input handshake and holds the result on a valid/ready
//   output handshake. Area-cheap arithmetic for the game-of-life neighbour/counter datapaths.
// PARAMETERS
//   N  8  operand/result width in bits (N >= 2)
// PORTS
//   clk        in   1  single clock, all state on rising edge
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  operands a/b valid
//   in_ready   out  1  block can accept operands (high only in S_IDLE)
//   a          in   N  minuend (unsigned)
//   b          in   N  subtrahend (unsigned)
//   out_valid  out  1  diff/borrow valid (high only in S_DONE)
//   out_ready  in   1  consumer takes result
//   diff       out  N  a - b mod 2^N
//   borrow     out  1  1 when a < b (unsigned)
//   overflow   out  1  signed overflow (present only with SERIAL_SUB_OVF_EN)
// BEHAVIOUR
//   - Reset (rst high at a rising edge): state=S_IDLE, bit counter=0, borrow reg=0, diff reg=0,
//     overflow=0. Aborts any operation in flight; no partial result is ever presented.
//   - Outputs after reset: in_ready=1, out_valid=0, diff=0, borrow=0.
//   - FSM:
//     S_IDLE: in_ready=1. On in_valid&&in_ready, latch a,b; counter=0; borrow=0 -> S_BUSY.
//     S_BUSY: each cycle, bit i=counter:
//       d_i = a_i ^ b_i ^ bw
//       bw' = (~a_i & b_i) | (~(a_i ^ b_i) & bw)
//       d_i shifts into diff MSB (right shift); operand shift regs shift right.
//       After bit N-1 -> S_DONE. in_valid ignored; a/b may change freely.
//     S_DONE: out_valid=1; diff, borrow, overflow held stable until out_ready.
//       On out_ready -> S_IDLE.
//   - Latency: out_valid rises on the Nth rising edge after the accepting edge.
//   - Throughput: one result per N+2 cycles with in_valid and out_ready held high.
//   - Counter width $clog2(N). Terminal compare is counter==N-1; no wrap past N-1.
//   - borrow = final bw. diff is exact modulo 2^N: 0x00-0x01 -> 0xFF, borrow=1.
//   - Simultaneous events:
//     rst wins over any handshake.
//     out_ready while not S_DONE has no effect.
//     in_valid outside S_IDLE is not accepted and is not queued.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined:
//     - Adds the overflow port.
//     - overflow = (a[N-1]^b[N-1]) & (a[N-1]^diff[N-1]), using latched operand MSBs;
//       registered at S_BUSY->S_DONE, valid with out_valid, 0 after reset.
//   SERIAL_SUB_OVF_EN undefined:
//     - overflow port and logic absent; all other behaviour identical.
// STRUCTURE
//   Package serial_sub_pkg:
//     - typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sub_state_t
//     - no width constants; N stays a module parameter.
//   Sub-module subtractor_1 (a, b, b_in -> d, b_out): combinational full-subtractor cell,
//     one instance.
//   Top module contains the FSM, counter, operand/result shift regs and borrow flop.
// TESTING (N=8)
//   1. a=0x05, b=0x03 -> diff=0x02, borrow=0; out_valid exactly 8 edges after accept.
//   2. a=0x03, b=0x05 -> diff=0xFE, borrow=1; a=0x00, b=0x01 -> diff=0xFF, borrow=1.
//   3. a=0xFF, b=0x00 -> diff=0xFF, borrow=0; a=0xA5, b=0xA5 -> diff=0x00, borrow=0.
//   4. Backpressure: out_ready low 5 cycles in S_DONE, in_valid pulsed with a=0x11 ->
//      diff/borrow stable, in_ready=0, pulse not accepted, next result unaffected.
//   5. rst at 3rd S_BUSY cycle -> next cycle in_ready=1, out_valid=0, diff=0.
//      Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1 (with SERIAL_SUB_OVF_EN).
//   6. Back-to-back: in_valid and out_ready held 1 with 4 operand pairs ->
//      results in order, one every 10 cycles, and a, b changed mid-BUSY do not corrupt
//      the result.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  modport master (
    output in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    input  overflow,
`endif
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    output overflow,
`endif
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/subtractor_1.sv
// Single-bit full-subtractor cell: d = a - b - b_in, with borrow out.
module subtractor_1 (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);
  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock through one cell.
// Optional signed overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(N);

  sub_state_t    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sh, b_sh, diff_q;
  logic          bw, in_ready_q, out_valid_q;
  logic          d_bit, bw_nxt;
`ifdef SERIAL_SUB_OVF_EN
  logic          ovf_q;
`endif

  subtractor_1 u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .b_in (bw),
    .d    (d_bit),
    .b_out(bw_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      bw          <= 1'b0;
      diff_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            cnt        <= '0;
            bw         <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          bw     <= bw_nxt;
          diff_q <= {d_bit, diff_q[N-1:1]};
          if (cnt == CW'(N-1)) begin
            out_valid_q <= 1'b1;
            state       <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit the shift-reg LSBs hold the latched operand MSBs.
            ovf_q       <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = bw;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=8): vector table plus handshake corner cases.
module tb_serial_subtractor;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.N(N)) bus();

  serial_subtractor #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  int applied = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ovf(input string nm, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    chk(nm, {31'd0, bus.overflow}, {31'd0, exp});
`else
    if (exp === 1'bx) chk(nm, 32'd0, 32'd1);
`endif
  endtask

  // Called at a negedge; returns at a negedge with the block idle again.
  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tbv,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int k;
    k = 0;
    while (!bus.in_ready && k < 30) begin @(negedge clk); k++; end
    chk({nm, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a = ta; bus.b = tbv; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = ~ta; bus.b = 8'h5A;
    k = 0;
    while (!bus.out_valid && k < 30) begin @(posedge clk); k++; @(negedge clk); end
    chk({nm, " latency"}, k, 32'd8);
    chk({nm, " diff"}, {24'd0, bus.diff}, {24'd0, ed});
    chk({nm, " borrow"}, {31'd0, bus.borrow}, {31'd0, eb});
    chk_ovf({nm, " ovf"}, eo);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  vec_t vt [7];
  logic [7:0] pa [4], pb [4], pd [4];
  logic       pbw [4];
  logic [7:0] rd [4];
  logic       rb [4];
  int         rc [4];

  initial begin
    int k, nxt, nres;
    vt[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vt[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vt[4] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0};
    vt[5] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    pa = '{8'h10, 8'h01, 8'hC8, 8'h33};
    pb = '{8'h01, 8'h02, 8'h64, 8'h44};
    pd = '{8'h0F, 8'hFF, 8'h64, 8'hEF};
    pbw = '{1'b0, 1'b1, 1'b0, 1'b1};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst diff", {24'd0, bus.diff}, 32'd0);
    chk("rst borrow", {31'd0, bus.borrow}, 32'd0);
    chk_ovf("rst ovf", 1'b0);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].diff, vt[i].borrow, vt[i].ovf);

    // Backpressure: result held while out_ready is low; in_valid pulse is dropped.
    bus.a = 8'h3C; bus.b = 8'h0F; bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 30) begin @(posedge clk); k++; @(negedge clk); end
    chk("bp latency", k, 32'd8);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 1);
      bus.a = 8'h11; bus.b = 8'h01;
      chk($sformatf("bp diff%0d", i), {24'd0, bus.diff}, 32'h2D);
      chk($sformatf("bp borrow%0d", i), {31'd0, bus.borrow}, 32'd0);
      chk($sformatf("bp in_ready%0d", i), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("bp out_valid%0d", i), {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp not queued in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp not queued out_valid", {31'd0, bus.out_valid}, 32'd0);
    run_op("bp next", 8'h20, 8'h01, 8'h1F, 1'b0, 1'b0);

    // Reset during the third BUSY cycle aborts the operation.
    bus.a = 8'h55; bus.b = 8'h0F; bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort diff", {24'd0, bus.diff}, 32'd0);
    run_op("post abort", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // Back-to-back with in_valid/out_ready held high; operands scrambled while busy.
    bus.out_ready = 1'b1;
    nxt = 0; nres = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.out_valid && nres < 4) begin
        rd[nres] = bus.diff; rb[nres] = bus.borrow; rc[nres] = c; nres++;
      end
      if (bus.in_ready) begin
        bus.in_valid = (nxt < 4);
        if (nxt < 4) begin bus.a = pa[nxt]; bus.b = pb[nxt]; nxt++; end
      end else begin
        bus.a = 8'($urandom); bus.b = 8'($urandom);
      end
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("b2b count", nres, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < nres) begin
        chk($sformatf("b2b diff%0d", i), {24'd0, rd[i]}, {24'd0, pd[i]});
        chk($sformatf("b2b borrow%0d", i), {31'd0, rb[i]}, {31'd0, pbw[i]});
        if (i > 0) chk($sformatf("b2b spacing%0d", i), rc[i] - rc[i-1], 32'd10);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
